spi_reg_ctrl: RTL and testbench
===============================

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 32: bus cycles to wait for bus_ack before aborting an access.
REQ-002 Parameter FILL, default 8'hFF: byte returned to SPI on a timed-out read or when no data is available.
REQ-003 clk  in  1  single clock; all logic is synchronous to its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ssn  in  1  SPI chip select, active low; already synchronous to clk.
REQ-006 api_start  in  1  one-cycle pulse: first (command) byte complete, on api_din.
REQ-007 api_next  in  1  one-cycle pulse per completed received byte, including the command byte.
REQ-008 api_strobe  in  1  one-cycle pulse: SPI slave has just captured api_dout for transmission.
REQ-009 api_din  in  8  received byte, valid while api_next is high.
REQ-010 api_dout  out  8  byte for the SPI slave to transmit next.
REQ-011 bus_req  out  1  register-bus request.
REQ-012 bus_we  out  1  1 = write, 0 = read.
REQ-013 bus_addr  out  7  register address.
REQ-014 bus_wdata  out  8  write data.
REQ-015 bus_rdata  in  8  read data, valid when bus_ack is high.
REQ-016 bus_ack  in  1  one-cycle completion pulse from the target.
REQ-017 err  out  1  sticky error: timeout or read underrun.
REQ-018 busy  out  1  high when state is not IDLE.

Function
REQ-019 The command byte is decoded on api_start & api_next as follows: api_din[7] is 1 for write, 0 for read; api_din[6:0] is the start address, latched into the address counter.
REQ-020 States: IDLE, WR_WAIT, WR_BUS, RD_BUS, RD_READY.
REQ-021 IDLE transitions: write command goes to WR_WAIT; read command goes to RD_BUS in the next cycle with bus_req=1 and bus_we=0.
REQ-022 WR_WAIT: on api_next with api_start low, the block drives bus_wdata=api_din and bus_addr=counter, asserts bus_req with bus_we=1, and moves to WR_BUS.
REQ-023 WR_BUS: on bus_ack, the block deasserts bus_req in the following cycle, increments the counter, and returns to WR_WAIT.
REQ-024 RD_BUS: on bus_ack, api_dout is loaded with bus_rdata in the next cycle and the state moves to RD_READY.
REQ-025 RD_READY: on api_strobe, the block increments the counter and reissues a read (prefetch), moving to RD_BUS.
REQ-026 Bus handshake: bus_req, bus_we, bus_addr and bus_wdata stay stable from assertion until the cycle after bus_ack; at most one access is outstanding.
REQ-027 Address arithmetic is 7-bit modulo: 7'h7F+1 = 7'h00, with no flag.
REQ-028 Timeout: a counter clears when bus_req rises; if it reaches TIMEOUT-1 without bus_ack, the block drops bus_req, sets err, and treats the access as acked (read data = FILL).
REQ-029 Read underrun: api_strobe in RD_BUS sets err; the in-flight read still completes, its data goes to api_dout, and the counter advances only once per completed read.
REQ-030 api_next during a read transaction and api_strobe during a write transaction are ignored.
REQ-031 Write overrun: api_next in WR_BUS sets err and the byte is discarded.
REQ-032 ssn rising in any state: no new access is issued; an in-flight access completes or times out, then the state returns to IDLE.
REQ-033 When ssn is high and the state is IDLE, api_dout = FILL.
REQ-034 A second api_start while busy is treated as a new command after any in-flight access completes.
REQ-035 err clears only on reset.

Reset
REQ-036 On reset: state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, api_dout=FILL, err=0, busy=0, timeout counter=0.
REQ-037 Reset asserted mid-access drops bus_req in the next cycle without waiting for bus_ack.

Structure
REQ-038 Package spi_reg_pkg holds: the state enum, the command-bit position (7), the address width (7), and the FILL default.
REQ-039 The block is a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-040 Write burst: command 8'h90, then bytes 8'hA1 and 8'hB2 -> bus writes to addr 0x10=A1 and 0x11=B2, err=0.
REQ-041 Read burst with 2-cycle ack: command 8'h7E, target returns 0x55, 0x66, 0x77 -> reads at 0x7E, 0x7F, 0x00 (wrap); api_dout sequence is 55, 66, 77.
REQ-042 No ack: read command 8'h05 with bus_ack held low -> bus_req drops after TIMEOUT cycles, api_dout=8'hFF, err=1.
REQ-043 Underrun: ack delayed past the next api_strobe -> err=1, no address skipped.
REQ-044 Abort: ssn rises during WR_BUS -> the write completes on ack, the state goes to IDLE, and no further bus_req.
REQ-045 Reset during RD_BUS -> bus_req=0 next cycle and all outputs at their reset values.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI-to-register-bus bridge.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_WAIT,
    ST_WR_BUS,
    ST_RD_BUS,
    ST_RD_READY
  } state_t;

  localparam int unsigned CMD_BIT      = 7;
  localparam int unsigned ADDR_W       = 7;
  localparam logic [7:0]  FILL_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_reg_ctrl.sv
// Bridges SPI slave byte events to a single-outstanding register bus with
// auto-incrementing address, read prefetch, timeout and sticky error.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int unsigned TIMEOUT = 32,
  parameter logic [7:0]  FILL    = FILL_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ssn,
  input  logic              api_start,
  input  logic              api_next,
  input  logic              api_strobe,
  input  logic [7:0]        api_din,
  output logic [7:0]        api_dout,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic [7:0]        bus_rdata,
  input  logic              bus_ack,
  output logic              err,
  output logic              busy
);

  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr, r_bus_addr, w_addr_inc;
  logic [7:0]          r_wdata, r_dout, r_pend_cmd, w_cmd_byte;
  logic [TMO_W-1:0]    r_tmo;
  logic                r_req, r_we, r_err, r_abort, r_pend;
  logic                w_cmd_now, w_tmo, w_done, w_in_bus;
  logic                w_decode, w_load_cmd, w_issue_wr, w_issue_rd, w_inc;

  assign w_cmd_now  = api_start & api_next;
  // A command arriving this cycle wins over one parked during a bus access.
  assign w_cmd_byte = w_cmd_now ? api_din : r_pend_cmd;
  assign w_addr_inc = r_addr + 1'b1;
  assign w_tmo      = r_req && (r_tmo == TMO_W'(TIMEOUT - 1));
  assign w_done     = r_req && (bus_ack || w_tmo);
  assign w_in_bus   = (r_state == ST_WR_BUS) || (r_state == ST_RD_BUS);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_decode    = 1'b0;
    w_load_cmd  = 1'b0;
    w_issue_wr  = 1'b0;
    w_issue_rd  = 1'b0;
    w_inc       = 1'b0;
    unique case (r_state)
      ST_IDLE:
        w_decode = !ssn && (w_cmd_now || r_pend);
      ST_WR_WAIT:
        if (ssn)           w_state_nxt = ST_IDLE;
        else if (w_cmd_now) w_decode   = 1'b1;
        else if (api_next) begin
          w_issue_wr  = 1'b1;
          w_state_nxt = ST_WR_BUS;
        end
      ST_WR_BUS:
        if (w_done) begin
          w_inc       = 1'b1;
          w_state_nxt = (ssn || r_abort || r_pend || w_cmd_now) ? ST_IDLE : ST_WR_WAIT;
        end
      ST_RD_BUS:
        if (w_done)
          w_state_nxt = (ssn || r_abort || r_pend || w_cmd_now) ? ST_IDLE : ST_RD_READY;
      ST_RD_READY:
        if (ssn)            w_state_nxt = ST_IDLE;
        else if (w_cmd_now) w_decode    = 1'b1;
        else if (api_strobe) begin
          w_inc       = 1'b1;
          w_issue_rd  = 1'b1;
          w_state_nxt = ST_RD_BUS;
        end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_decode) begin
      w_load_cmd = 1'b1;
      if (w_cmd_byte[CMD_BIT]) begin
        w_state_nxt = ST_WR_WAIT;
      end else begin
        w_issue_rd  = 1'b1;
        w_state_nxt = ST_RD_BUS;
      end
    end
  end

  always_comb begin
    busy      = (r_state != ST_IDLE);
    api_dout  = ((r_state == ST_IDLE) && ssn) ? FILL : r_dout;
    bus_req   = r_req;
    bus_we    = r_we;
    bus_addr  = r_bus_addr;
    bus_wdata = r_wdata;
    err       = r_err;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_bus_addr <= '0;
      r_wdata    <= '0;
      r_dout     <= FILL;
      r_err      <= 1'b0;
      r_tmo      <= '0;
      r_abort    <= 1'b0;
      r_pend     <= 1'b0;
      r_pend_cmd <= '0;
    end else begin
      if (w_load_cmd) r_addr <= w_cmd_byte[ADDR_W-1:0];
      else if (w_inc) r_addr <= w_addr_inc;

      if (w_issue_rd) begin
        r_req      <= 1'b1;
        r_we       <= 1'b0;
        r_bus_addr <= w_load_cmd ? w_cmd_byte[ADDR_W-1:0] : w_addr_inc;
      end else if (w_issue_wr) begin
        r_req      <= 1'b1;
        r_we       <= 1'b1;
        r_bus_addr <= r_addr;
        r_wdata    <= api_din;
      end else if (w_done) begin
        r_req <= 1'b0;
      end

      if (w_issue_rd || w_issue_wr) r_tmo <= '0;
      else if (r_req)               r_tmo <= r_tmo + 1'b1;

      if ((r_state == ST_RD_BUS) && w_done) r_dout <= bus_ack ? bus_rdata : FILL;

      if ((w_done && !bus_ack) ||
          ((r_state == ST_RD_BUS) && api_strobe) ||
          ((r_state == ST_WR_BUS) && api_next && !api_start))
        r_err <= 1'b1;

      r_abort <= (w_in_bus && !w_done) ? (r_abort | ssn) : 1'b0;

      if (ssn) begin
        r_pend <= 1'b0;
      end else if (w_in_bus && w_cmd_now) begin
        r_pend     <= 1'b1;
        r_pend_cmd <= api_din;
      end else if (w_load_cmd) begin
        r_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench: behavioural SPI host, register target and memory model.
module tb_spi_reg_ctrl;
  import spi_reg_pkg::*;

  localparam int unsigned TMO = 32;
  localparam int unsigned GAP = 16;

  logic       clk = 1'b0;
  logic       reset, ssn, api_start, api_next, api_strobe;
  logic [7:0] api_din, api_dout, bus_wdata, bus_rdata;
  logic       bus_req, bus_we, bus_ack, err, busy;
  logic [6:0] bus_addr;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  tmem [128];
  logic [7:0]  mmem [128];
  int unsigned ack_delay = 0;
  bit          no_ack = 1'b0;
  logic [15:0] obs_q [$];
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  spi_reg_ctrl #(.TIMEOUT(TMO), .FILL(8'hFF)) dut (
    .clk(clk), .reset(reset), .ssn(ssn), .api_start(api_start),
    .api_next(api_next), .api_strobe(api_strobe), .api_din(api_din),
    .api_dout(api_dout), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .err(err), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] bus_word();
    return {bus_we, bus_addr, bus_we ? bus_wdata : 8'h00};
  endfunction

  // Register target: acks each request after ack_delay cycles.
  initial begin : responder
    int unsigned wcnt;
    bit acked;
    wcnt = 0; acked = 1'b0;
    bus_ack = 1'b0; bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (!bus_req) begin
        wcnt = 0; acked = 1'b0;
      end else if (!acked && !no_ack) begin
        if (wcnt >= ack_delay) begin
          bus_ack = 1'b1; acked = 1'b1;
          bus_rdata = tmem[bus_addr];
          if (bus_we) tmem[bus_addr] = bus_wdata;
        end else begin
          wcnt++;
        end
      end
    end
  end

  initial begin : monitor
    bit prev;
    logic [15:0] cap;
    prev = 1'b0; cap = '0;
    forever begin
      @(negedge clk);
      if (bus_req) begin
        if (!prev) begin
          cap = bus_word();
          obs_q.push_back(cap);
        end else begin
          check_eq("bus_stable", 32'(bus_word()), 32'(cap));
        end
      end
      prev = bus_req;
    end
  end

  task automatic cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit st);
    api_din = b; api_start = st; api_next = 1'b1;
    cycles(1);
    api_next = 1'b0; api_start = 1'b0;
  endtask

  task automatic do_strobe();
    api_strobe = 1'b1;
    cycles(1);
    api_strobe = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; ssn = 1'b1; api_start = 1'b0; api_next = 1'b0;
    api_strobe = 1'b0; api_din = '0;
    cycles(2);
    reset = 1'b0;
    cycles(1);
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic exp_wr(input logic [6:0] a, input logic [7:0] d);
    exp_q.push_back({1'b1, a, d});
    mmem[a] = d;
  endtask

  task automatic exp_rd(input logic [6:0] a);
    exp_q.push_back({1'b0, a, 8'h00});
  endtask

  task automatic compare_bus(input string tag);
    check_eq({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check_eq(tag, 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic wr_frame(input logic [6:0] a, input int unsigned n);
    logic [7:0] d;
    ssn = 1'b0; cycles(2);
    send({1'b1, a}, 1'b1); cycles(4);
    for (int unsigned i = 0; i < n; i++) begin
      d = 8'($urandom);
      send(d, 1'b0);
      exp_wr(a + 7'(i), d);
      cycles(GAP);
    end
    ssn = 1'b1; cycles(3);
  endtask

  task automatic rd_frame(input logic [6:0] a, input int unsigned n, input string tag);
    logic [6:0] p;
    p = a;
    ssn = 1'b0; cycles(2);
    send({1'b0, a}, 1'b1); exp_rd(p); cycles(GAP);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq(tag, 32'(api_dout), 32'(mmem[p]));
      if (i + 1 < n) begin
        do_strobe();
        p = p + 7'd1;
        exp_rd(p);
        cycles(GAP);
      end
    end
    ssn = 1'b1; cycles(3);
    @(negedge clk);
    check_eq({tag, "_fill"}, 32'(api_dout), 32'hFF);
    check_eq({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int unsigned cnt;
    logic [7:0] v;
    for (int i = 0; i < 128; i++) begin
      v = 8'($urandom);
      tmem[i] = v; mmem[i] = v;
    end
    do_reset();

    @(negedge clk);
    check_eq("rst_req",   32'(bus_req),   32'h0);
    check_eq("rst_we",    32'(bus_we),    32'h0);
    check_eq("rst_addr",  32'(bus_addr),  32'h0);
    check_eq("rst_wdata", 32'(bus_wdata), 32'h0);
    check_eq("rst_dout",  32'(api_dout),  32'hFF);
    check_eq("rst_err",   32'(err),       32'h0);
    check_eq("rst_busy",  32'(busy),      32'h0);

    // Directed write burst
    ack_delay = 1;
    ssn = 1'b0; cycles(2);
    send(8'h90, 1'b1); cycles(4);
    send(8'hA1, 1'b0); exp_wr(7'h10, 8'hA1); cycles(GAP);
    send(8'hB2, 1'b0); exp_wr(7'h11, 8'hB2); cycles(GAP);
    ssn = 1'b1; cycles(3);
    compare_bus("wr_burst");
    check_eq("wr_burst_err", 32'(err), 32'h0);
    check_eq("wr_mem10", 32'(tmem[7'h10]), 32'hA1);
    check_eq("wr_mem11", 32'(tmem[7'h11]), 32'hB2);

    // Read burst with wrap
    tmem[7'h7E] = 8'h55; tmem[7'h7F] = 8'h66; tmem[7'h00] = 8'h77;
    mmem[7'h7E] = 8'h55; mmem[7'h7F] = 8'h66; mmem[7'h00] = 8'h77;
    rd_frame(7'h7E, 3, "rd_wrap");
    compare_bus("rd_wrap_bus");
    check_eq("rd_wrap_err", 32'(err), 32'h0);

    // No ack: timeout
    no_ack = 1'b1;
    ssn = 1'b0; cycles(2);
    send(8'h05, 1'b1); exp_rd(7'h05);
    cnt = 0;
    while (bus_req && cnt < 200) begin
      @(negedge clk);
      if (bus_req) cnt++;
    end
    check_eq("tmo_len", 32'(cnt), 32'(TMO));
    cycles(2);
    @(negedge clk);
    check_eq("tmo_dout", 32'(api_dout), 32'hFF);
    check_eq("tmo_err",  32'(err),      32'h1);
    ssn = 1'b1; cycles(4);
    @(negedge clk);
    check_eq("tmo_err_sticky", 32'(err), 32'h1);
    compare_bus("tmo_bus");
    no_ack = 1'b0;
    do_reset();
    @(negedge clk);
    check_eq("tmo_err_cleared", 32'(err), 32'h0);

    // Randomised frames
    for (int k = 0; k < 8; k++) begin
      ack_delay = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1)
        wr_frame(7'($urandom), $urandom_range(1, 4));
      else
        rd_frame(7'($urandom), $urandom_range(1, 4), "rnd_rd");
      compare_bus("rnd_bus");
    end
    check_eq("rnd_err", 32'(err), 32'h0);

    // Read underrun
    ack_delay = 8;
    ssn = 1'b0; cycles(2);
    send(8'h20, 1'b1); exp_rd(7'h20); cycles(GAP);
    @(negedge clk);
    check_eq("ur_d0", 32'(api_dout), 32'(mmem[7'h20]));
    check_eq("ur_err0", 32'(err), 32'h0);
    do_strobe(); exp_rd(7'h21); cycles(2);
    do_strobe();
    cycles(GAP);
    @(negedge clk);
    check_eq("ur_err1", 32'(err), 32'h1);
    check_eq("ur_d1", 32'(api_dout), 32'(mmem[7'h21]));
    do_strobe(); exp_rd(7'h22); cycles(GAP);
    @(negedge clk);
    check_eq("ur_d2", 32'(api_dout), 32'(mmem[7'h22]));
    ssn = 1'b1; cycles(3);
    compare_bus("ur_bus");
    do_reset();

    // ssn abort during a write access
    ack_delay = 6;
    ssn = 1'b0; cycles(2);
    send(8'hC0, 1'b1); cycles(4);
    send(8'h3C, 1'b0); exp_wr(7'h40, 8'h3C);
    cycles(2);
    ssn = 1'b1;
    @(negedge clk);
    check_eq("ab_busy_inflight", 32'(busy), 32'h1);
    cycles(12);
    @(negedge clk);
    check_eq("ab_busy_done", 32'(busy), 32'h0);
    send(8'h99, 1'b0);
    send(8'h11, 1'b1);
    cycles(10);
    @(negedge clk);
    check_eq("ab_busy_end", 32'(busy), 32'h0);
    check_eq("ab_err", 32'(err), 32'h0);
    check_eq("ab_mem", 32'(tmem[7'h40]), 32'h3C);
    compare_bus("ab_bus");

    // Reset during a read access
    ack_delay = 10;
    ssn = 1'b0; cycles(2);
    send(8'h30, 1'b1); exp_rd(7'h30); cycles(3);
    @(negedge clk);
    check_eq("rr_req_before", 32'(bus_req), 32'h1);
    reset = 1'b1;
    cycles(1);
    @(negedge clk);
    check_eq("rr_req",   32'(bus_req),   32'h0);
    check_eq("rr_we",    32'(bus_we),    32'h0);
    check_eq("rr_addr",  32'(bus_addr),  32'h0);
    check_eq("rr_wdata", 32'(bus_wdata), 32'h0);
    check_eq("rr_dout",  32'(api_dout),  32'hFF);
    check_eq("rr_err",   32'(err),       32'h0);
    check_eq("rr_busy",  32'(busy),      32'h0);
    reset = 1'b0; ssn = 1'b1;
    cycles(20);
    compare_bus("rr_bus");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
